// File: rtl/lbus_crypto_pkg.sv
// Shared address map, CONT bit positions and sizing constants for the
// lbus_crypto_regs local-bus slave.
package lbus_crypto_pkg;

  localparam logic [15:0] CONT_ADDR  = 16'h0002;
  localparam logic [15:0] KEY_BASE   = 16'h0100;
  localparam logic [15:0] ITEXT_BASE = 16'h0140;
  localparam logic [15:0] OTEXT_BASE = 16'h0180;
  localparam logic [15:0] VER_ADDR   = 16'hFFFC;

  localparam int CONT_DATA_BIT = 0;
  localparam int CONT_KEY_BIT  = 1;
  localparam int CONT_CRST_BIT = 2;

  localparam int NWORDS   = 8;
  localparam int CRST_LEN = 4;

  // Every 128-bit register bank occupies an 8-word aligned window.
  function automatic logic in_block(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:3] == base[15:3];
  endfunction

endpackage

// File: rtl/lbus_wr_strobe.sv
// Registers the active-low write strobe and emits a single-cycle commit on
// its low->high transition, so a long low pulse still commits only once.
module lbus_wr_strobe (
  input  logic clk,
  input  logic rst,
  input  logic wrn_i,
  output logic wr_commit_o
);

  logic wrn_q;

  // Resets to the idle-high level so leaving reset never looks like a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrn_q <= 1'b1;
    else     wrn_q <= wrn_i;
  end

  assign wr_commit_o = ~wrn_q & wrn_i;

endmodule

// File: rtl/lbus_crypto_regs.sv
// Local-bus register slave for the block-cipher core: KEY/ITEXT/OTEXT banks,
// CONT control/status and krdy/drdy handshake. Optional LBUS_TRIG_OUT_EN adds a capture trigger.
module lbus_crypto_regs
  import lbus_crypto_pkg::*;
#(
  parameter logic [15:0] VERSION_ID = 16'hC310,
  parameter bit          CLR_OTEXT  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  lbus_a,
  input  logic [15:0]  lbus_di,
  input  logic         lbus_wrn,
  input  logic         lbus_rdn,
  output logic [15:0]  lbus_do,
  output logic [127:0] blk_kin,
  output logic [127:0] blk_din,
  output logic         blk_krdy,
  output logic         blk_drdy,
  input  logic         blk_kvld,
  input  logic         blk_dvld,
  input  logic [127:0] blk_dout,
  output logic         blk_rstn,
  output logic         trig_out
);

  logic        wr_commit;
  logic [15:0] key_q   [NWORDS];
  logic [15:0] key_d   [NWORDS];
  logic [15:0] itext_q [NWORDS];
  logic [15:0] itext_d [NWORDS];
  logic [15:0] otext_q [NWORDS];
  logic [15:0] otext_d [NWORDS];
  logic        kbusy_q, kbusy_d, dbusy_q, dbusy_d;
  logic        krdy_q, krdy_d, drdy_q, drdy_d;
  logic [2:0]  crst_q, crst_d;
  logic [15:0] do_q, do_d, rd_word;
  logic [2:0]  widx;
  logic        cont_wr, idle, key_go, data_go, crst_go;

  lbus_wr_strobe u_wr_strobe (
    .clk         (clk),
    .rst         (rst),
    .wrn_i       (lbus_wrn),
    .wr_commit_o (wr_commit)
  );

  assign widx    = lbus_a[2:0];
  assign cont_wr = wr_commit && (lbus_a == CONT_ADDR);
  assign idle    = ~kbusy_q & ~dbusy_q;
  // Core reset dominates; with both start bits set the key start wins.
  assign crst_go = cont_wr & lbus_di[CONT_CRST_BIT];
  assign key_go  = cont_wr & ~lbus_di[CONT_CRST_BIT] & idle & lbus_di[CONT_KEY_BIT];
  assign data_go = cont_wr & ~lbus_di[CONT_CRST_BIT] & idle & ~lbus_di[CONT_KEY_BIT]
                 & lbus_di[CONT_DATA_BIT];
  assign blk_rstn = (crst_q == 3'd0);

  always_comb begin
    rd_word = '0;
    if (lbus_a == CONT_ADDR)               rd_word = {13'b0, ~blk_rstn, dbusy_q, kbusy_q};
    else if (in_block(lbus_a, KEY_BASE))   rd_word = key_q[widx];
    else if (in_block(lbus_a, ITEXT_BASE)) rd_word = itext_q[widx];
    else if (in_block(lbus_a, OTEXT_BASE)) rd_word = otext_q[widx];
    else if (lbus_a == VER_ADDR)           rd_word = VERSION_ID;
  end

  always_comb begin
    key_d   = key_q;
    itext_d = itext_q;
    otext_d = otext_q;
    kbusy_d = kbusy_q & ~blk_kvld;
    dbusy_d = dbusy_q & ~blk_dvld;
    krdy_d  = key_go;
    drdy_d  = data_go;
    crst_d  = (crst_q != 3'd0) ? crst_q - 3'd1 : 3'd0;
    if (wr_commit && in_block(lbus_a, KEY_BASE))   key_d[widx]   = lbus_di;
    if (wr_commit && in_block(lbus_a, ITEXT_BASE)) itext_d[widx] = lbus_di;
    if (key_go) kbusy_d = 1'b1;
    if (data_go) begin
      dbusy_d = 1'b1;
      if (CLR_OTEXT) for (int i = 0; i < NWORDS; i++) otext_d[i] = '0;
    end
    if (crst_go) begin
      crst_d  = 3'(CRST_LEN);
      kbusy_d = 1'b0;
      dbusy_d = 1'b0;
    end
    // A fresh ciphertext overrides the start-time clear.
    if (blk_dvld) for (int i = 0; i < NWORDS; i++) otext_d[i] = blk_dout[127-16*i -: 16];
    do_d = lbus_rdn ? 16'h0000 : rd_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) begin
        key_q[i]   <= '0;
        itext_q[i] <= '0;
        otext_q[i] <= '0;
      end
      kbusy_q <= 1'b0;
      dbusy_q <= 1'b0;
      krdy_q  <= 1'b0;
      drdy_q  <= 1'b0;
      crst_q  <= 3'd0;
      do_q    <= '0;
    end else begin
      key_q   <= key_d;
      itext_q <= itext_d;
      otext_q <= otext_d;
      kbusy_q <= kbusy_d;
      dbusy_q <= dbusy_d;
      krdy_q  <= krdy_d;
      drdy_q  <= drdy_d;
      crst_q  <= crst_d;
      do_q    <= do_d;
    end
  end

  always_comb begin
    blk_kin = '0;
    blk_din = '0;
    for (int i = 0; i < NWORDS; i++) begin
      blk_kin[127-16*i -: 16] = key_q[i];
      blk_din[127-16*i -: 16] = itext_q[i];
    end
  end

  assign lbus_do  = do_q;
  assign blk_krdy = krdy_q;
  assign blk_drdy = drdy_q;

`ifdef LBUS_TRIG_OUT_EN
  logic trig_q, trig_d;

  // High from the drdy cycle through the dvld cycle.
  always_comb begin
    trig_d = trig_q;
    if (blk_dvld) trig_d = 1'b0;
    if (data_go)  trig_d = 1'b1;
    if (crst_go)  trig_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_q <= 1'b0;
    else     trig_q <= trig_d;
  end

  assign trig_out = trig_q;
`else
  assign trig_out = 1'b0;
`endif

endmodule

// File: tb/tb_lbus_crypto_regs.sv
// Self-checking bench for lbus_crypto_regs: behavioural model compared every
// cycle, directed scenarios with literal expectations, then randomized bus traffic.
module tb_lbus_crypto_regs;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  lbus_a = '0, lbus_di = '0;
  logic         lbus_wrn = 1'b1, lbus_rdn = 1'b1;
  logic [15:0]  lbus_do;
  logic [127:0] blk_kin, blk_din;
  logic         blk_krdy, blk_drdy;
  logic         blk_kvld = 1'b0, blk_dvld = 1'b0;
  logic [127:0] blk_dout = '0;
  logic         blk_rstn, trig_out;

  lbus_crypto_regs dut (
    .clk(clk), .rst(rst), .lbus_a(lbus_a), .lbus_di(lbus_di), .lbus_wrn(lbus_wrn),
    .lbus_rdn(lbus_rdn), .lbus_do(lbus_do), .blk_kin(blk_kin), .blk_din(blk_din),
    .blk_krdy(blk_krdy), .blk_drdy(blk_drdy), .blk_kvld(blk_kvld), .blk_dvld(blk_dvld),
    .blk_dout(blk_dout), .blk_rstn(blk_rstn), .trig_out(trig_out)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int krdy_seen = 0, drdy_seen = 0, rstn_low = 0;

  // Reference state
  logic [15:0] mkey [8];
  logic [15:0] mitext [8];
  logic [15:0] motext [8];
  bit          mkbusy, mdbusy, mkrdy, mdrdy, mtrig, mprev_wrn;
  int          mrst_left;
  logic [15:0] mdo;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mread(input logic [15:0] a);
    if (a == 16'h0002) return {13'b0, mrst_left > 0, mdbusy, mkbusy};
    if (a >= 16'h0100 && a <= 16'h0107) return mkey[a[2:0]];
    if (a >= 16'h0140 && a <= 16'h0147) return mitext[a[2:0]];
    if (a >= 16'h0180 && a <= 16'h0187) return motext[a[2:0]];
    if (a == 16'hFFFC) return 16'hC310;
    return 16'h0000;
  endfunction

  function automatic logic [127:0] pack(input logic [15:0] w [8]);
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[127-16*i -: 16] = w[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mkey[i] = '0; mitext[i] = '0; motext[i] = '0;
    end
    mkbusy = 0; mdbusy = 0; mkrdy = 0; mdrdy = 0; mtrig = 0;
    mprev_wrn = 1; mrst_left = 0; mdo = '0;
  endtask

  task automatic model_step();
    bit          commit, idle;
    logic [15:0] rd;
    commit = !mprev_wrn && lbus_wrn;
    idle   = !mkbusy && !mdbusy;
    rd     = mread(lbus_a);
    mkrdy = 0; mdrdy = 0;
    if (blk_kvld) mkbusy = 0;
    if (blk_dvld) mdbusy = 0;
    if (mrst_left > 0) mrst_left--;
    if (commit) begin
      if (lbus_a >= 16'h0100 && lbus_a <= 16'h0107) mkey[lbus_a[2:0]] = lbus_di;
      else if (lbus_a >= 16'h0140 && lbus_a <= 16'h0147) mitext[lbus_a[2:0]] = lbus_di;
      else if (lbus_a == 16'h0002) begin
        if (lbus_di[2]) begin
          mrst_left = 4; mkbusy = 0; mdbusy = 0; mtrig = 0;
        end else if (idle && lbus_di[1]) begin
          mkrdy = 1; mkbusy = 1;
        end else if (idle && lbus_di[0]) begin
          mdrdy = 1; mdbusy = 1;
          for (int i = 0; i < 8; i++) motext[i] = '0;
        end
      end
    end
    if (blk_dvld) begin
      for (int i = 0; i < 8; i++) motext[i] = blk_dout[127-16*i -: 16];
      mtrig = 0;
    end
    if (mdrdy) mtrig = 1;
    mdo = lbus_rdn ? 16'h0000 : rd;
    mprev_wrn = lbus_wrn;
  endtask

  // Per-cycle compare against the model
  initial begin
    logic exp_trig;
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
`ifdef LBUS_TRIG_OUT_EN
      exp_trig = mtrig;
`else
      exp_trig = 1'b0;
`endif
      chk("lbus_do", 128'(lbus_do), 128'(mdo));
      chk("blk_kin", blk_kin, pack(mkey));
      chk("blk_din", blk_din, pack(mitext));
      chk("blk_krdy", 128'(blk_krdy), 128'(mkrdy));
      chk("blk_drdy", 128'(blk_drdy), 128'(mdrdy));
      chk("blk_rstn", 128'(blk_rstn), 128'(mrst_left == 0));
      chk("trig_out", 128'(trig_out), 128'(exp_trig));
      if (blk_krdy) krdy_seen++;
      if (blk_drdy) drdy_seen++;
      if (!blk_rstn) rstn_low++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input int low, input bit rd);
    @(negedge clk);
    lbus_a = a; lbus_di = d; lbus_wrn = 1'b0; lbus_rdn = ~rd;
    repeat (low) @(negedge clk);
    lbus_wrn = 1'b1;
    @(negedge clk);
    lbus_rdn = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    lbus_a = a; lbus_rdn = 1'b0;
    @(negedge clk);
    d = lbus_do;
    lbus_rdn = 1'b1;
  endtask

  task automatic pulse_kvld();
    @(negedge clk); blk_kvld = 1'b1;
    @(negedge clk); blk_kvld = 1'b0;
  endtask

  task automatic pulse_dvld(input logic [127:0] v);
    @(negedge clk); blk_dout = v; blk_dvld = 1'b1;
    @(negedge clk); blk_dvld = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 16'h0002;
      1: return 16'h0100 + 16'($urandom_range(0, 7));
      2: return 16'h0140 + 16'($urandom_range(0, 7));
      3: return 16'h0180 + 16'($urandom_range(0, 7));
      4: return 16'hFFFC;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] r;
    int k0, d0, l0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_do", 128'(lbus_do), 128'h0);
    chk("reset_rstn", 128'(blk_rstn), 128'h1);
    rst = 1'b0;
    idle_cycles(2);

    // Key load and key-schedule start
    for (int i = 0; i < 8; i++)
      bus_write(16'h0100 + 16'(i), 16'(16'h1100 * i + 16'h0011 * (i + 1)), 1, 1'b0);
    chk("kin_literal", blk_kin, 128'h0011_1122_2233_3344_4455_5566_6677_7788);
    k0 = krdy_seen;
    bus_write(16'h0002, 16'h0002, 1, 1'b0);
    idle_cycles(3);
    chk("krdy_once", 128'(krdy_seen - k0), 128'd1);
    bus_read(16'h0002, r);
    chk("cont_kbusy", 128'(r), 128'h0001);
    pulse_kvld();
    bus_read(16'h0002, r);
    chk("cont_after_kvld", 128'(r), 128'h0000);

    // Encryption, busy rejection, ciphertext readback
    for (int i = 0; i < 8; i++) bus_write(16'h0140 + 16'(i), 16'($urandom), 1, 1'b0);
    d0 = drdy_seen;
    bus_write(16'h0002, 16'h0001, 1, 1'b0);
    idle_cycles(2);
    bus_write(16'h0002, 16'h0001, 1, 1'b0);
    idle_cycles(3);
    chk("drdy_once_while_busy", 128'(drdy_seen - d0), 128'd1);
    pulse_dvld(128'h69C4E0D86A7B0430D8CDB78070B4C55A);
    bus_read(16'h0180, r);
    chk("otext0", 128'(r), 128'h69C4);
    bus_read(16'h0187, r);
    chk("otext7", 128'(r), 128'hC55A);
    bus_read(16'h0002, r);
    chk("cont_after_dvld", 128'(r), 128'h0000);

    // Both start bits: key only
    k0 = krdy_seen; d0 = drdy_seen;
    bus_write(16'h0002, 16'h0003, 1, 1'b0);
    idle_cycles(3);
    chk("both_krdy", 128'(krdy_seen - k0), 128'd1);
    chk("both_no_drdy", 128'(drdy_seen - d0), 128'd0);
    pulse_kvld();

    // Long write pulse commits exactly once, at the rising edge
    k0 = krdy_seen;
    fork
      bus_write(16'h0002, 16'h0002, 20, 1'b0);
      begin idle_cycles(6); pulse_kvld(); end
    join
    idle_cycles(3);
    chk("long_pulse_one_commit", 128'(krdy_seen - k0), 128'd1);
    pulse_kvld();

    bus_read(16'hFFFC, r);
    chk("version", 128'(r), 128'hC310);
    bus_read(16'h0050, r);
    chk("unmapped", 128'(r), 128'h0000);

    // Core reset mid-encryption
    bus_write(16'h0002, 16'h0001, 1, 1'b0);
    idle_cycles(2);
`ifdef LBUS_TRIG_OUT_EN
    chk("trig_high", 128'(trig_out), 128'h1);
`endif
    l0 = rstn_low;
    bus_write(16'h0002, 16'h0004, 1, 1'b0);
    bus_read(16'h0002, r);
    chk("cont_in_core_reset", 128'(r), 128'h0004);
    idle_cycles(6);
    chk("rstn_low_cycles", 128'(rstn_low - l0), 128'd4);
    bus_read(16'h0002, r);
    chk("cont_after_core_reset", 128'(r), 128'h0000);
`ifdef LBUS_TRIG_OUT_EN
    chk("trig_dropped", 128'(trig_out), 128'h0);
`endif

    // Asynchronous reset while an encryption is in flight
    bus_write(16'h0002, 16'h0001, 1, 1'b0);
    @(negedge clk);
    lbus_a = 16'hFFFC; lbus_rdn = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_do", 128'(lbus_do), 128'h0);
    chk("async_drdy", 128'(blk_drdy), 128'h0);
    chk("async_din", blk_din, 128'h0);
    d0 = drdy_seen;
    @(negedge clk);
    rst = 1'b0; lbus_rdn = 1'b1;
    idle_cycles(10);
    chk("no_drdy_after_reset", 128'(drdy_seen - d0), 128'd0);
    bus_read(16'h0002, r);
    chk("cont_after_reset", 128'(r), 128'h0000);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: bus_write(rand_addr(), 16'($urandom), $urandom_range(1, 4), 1'($urandom));
        3, 4:    bus_read(rand_addr(), r);
        5:       bus_write(16'h0002, 16'($urandom_range(0, 7)), $urandom_range(1, 3), 1'($urandom));
        6:       pulse_kvld();
        7:       pulse_dvld({$urandom, $urandom, $urandom, $urandom});
        default: idle_cycles($urandom_range(1, 4));
      endcase
    end
    idle_cycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
